// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit registered ALU: operand width and op encodings.
package alu_pkg;

    localparam int WIDTH   = 16;
    localparam int SHAMT_W = $clog2(WIDTH);

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_AND = 3'd0;
    localparam alu_op_t OP_ADD = 3'd1;
    localparam alu_op_t OP_SUB = 3'd2;
    localparam alu_op_t OP_OR  = 3'd3;
    localparam alu_op_t OP_SHL = 3'd4;
    localparam alu_op_t OP_SHR = 3'd5;
    localparam alu_op_t OP_ASR = 3'd6;
    localparam alu_op_t OP_XOR = 3'd7;

endpackage

// File: rtl/alu16_if.sv
// Request/result bundle between an ALU client (master) and alu16 (slave).
interface alu16_if;
    import alu_pkg::*;

    logic             in_valid;
    alu_op_t          op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH:0]   out;
    logic             out_valid;
    logic             zero;

    modport master (
        output in_valid, op, in1, in2,
        input  out, out_valid, zero
    );

    modport slave (
        input  in_valid, op, in1, in2,
        output out, out_valid, zero
    );

endinterface

// File: rtl/alu16_shifter.sv
// Log-stage barrel shifter on the 17-bit extended operand; direction and fill bit
// select SHL, logical SHR or ASR, and 'big' saturates to an all-fill result.
module alu16_shifter
    import alu_pkg::*;
(
    input  logic [WIDTH:0]     data,
    input  logic [SHAMT_W-1:0] amt,
    input  logic               big,
    input  logic               left,
    input  logic               fill,
    output logic [WIDTH:0]     result
);

    localparam logic [WIDTH:0] ONES = '1;

    logic [WIDTH:0] cur;

    // Each stage conditionally shifts by 2^i; right shifts OR in the fill bits
    // that a plain logical shift would leave as zero.
    always_comb begin
        cur = data;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (amt[i]) begin
                if (left) begin
                    cur = cur << (1 << i);
                end else begin
                    cur = (cur >> (1 << i)) | (fill ? ~(ONES >> (1 << i)) : '0);
                end
            end
        end
    end

    assign result = big ? {(WIDTH+1){fill}} : cur;

endmodule

// File: rtl/alu16.sv
// 16-bit, 8-function ALU with one-cycle registered result; bit 16 carries
// carry, borrow or the shifted-out/sign bit depending on the op.
module alu16
    import alu_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    alu16_if.slave bus
);

    logic [WIDTH:0]     result;
    logic [WIDTH:0]     shift_data;
    logic [WIDTH:0]     shift_result;
    logic [SHAMT_W-1:0] shift_amt;
    logic               shift_big;
    logic               shift_left;
    logic               shift_fill;

    // Only ASR sign-extends into bit 16 and fills with the sign bit.
    assign shift_amt  = bus.in2[SHAMT_W-1:0];
    assign shift_big  = |bus.in2[WIDTH-1:SHAMT_W];
    assign shift_left = (bus.op == OP_SHL);
    assign shift_fill = (bus.op == OP_ASR) && bus.in1[WIDTH-1];
    assign shift_data = {shift_fill, bus.in1};

    alu16_shifter u_shifter (
        .data   (shift_data),
        .amt    (shift_amt),
        .big    (shift_big),
        .left   (shift_left),
        .fill   (shift_fill),
        .result (shift_result)
    );

    always_comb begin
        result = '0;
        case (bus.op)
            OP_AND:  result = {1'b0, bus.in1 & bus.in2};
            OP_ADD:  result = {1'b0, bus.in1} + {1'b0, bus.in2};
            OP_SUB:  result = {1'b0, bus.in1} - {1'b0, bus.in2};
            OP_OR:   result = {1'b0, bus.in1 | bus.in2};
            OP_SHL:  result = shift_result;
            OP_SHR:  result = shift_result;
            OP_ASR:  result = shift_result;
            OP_XOR:  result = {1'b0, bus.in1 ^ bus.in2};
            default: result = '0;
        endcase
    end

    // Result and zero flag only load on a valid op, so an undriven op while idle
    // never reaches state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.zero      <= 1'b1;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.out  <= result;
                bus.zero <= (result == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu16.sv
// Scoreboard bench for alu16: the driver pushes model results, a monitor pops
// and compares them one cycle later.
module tb_alu16;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    typedef struct {
        logic        valid;
        logic [16:0] out;
        logic        zero;
    } expect_t;

    expect_t     sb[$];
    string       tagq[$];
    logic [16:0] held_out  = '0;
    logic        held_zero = 1'b1;

    alu16_if bus();

    alu16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [16:0] modelAlu(input logic [2:0] op,
                                             input logic [15:0] a, input logic [15:0] b);
        int          ua;
        int          ub;
        int          amt;
        int          sx;
        logic        big;
        logic [31:0] r;
        ua  = {16'd0, a};
        ub  = {16'd0, b};
        amt = {28'd0, b[3:0]};
        big = |b[15:4];
        sx  = a[15] ? (ua - 65536) : ua;
        case (op)
            3'd0:    r = ua & ub;
            3'd1:    r = ua + ub;
            3'd2:    r = ua - ub;
            3'd3:    r = ua | ub;
            3'd4:    r = big ? 32'd0 : (ua << amt);
            3'd5:    r = big ? 32'd0 : (ua >> amt);
            3'd6:    r = big ? (a[15] ? 32'hFFFF_FFFF : 32'd0) : (sx >>> amt);
            default: r = ua ^ ub;
        endcase
        return r[16:0];
    endfunction

    task automatic applyStimulus(input string tag, input logic valid, input logic [2:0] op,
                                 input logic [15:0] a, input logic [15:0] b);
        expect_t e;
        @(negedge clk);
        bus.in_valid = valid;
        bus.op       = op;
        bus.in1      = a;
        bus.in2      = b;
        if (valid) begin
            held_out  = modelAlu(op, a, b);
            held_zero = (held_out == 17'd0);
        end
        e.valid = valid;
        e.out   = held_out;
        e.zero  = held_zero;
        sb.push_back(e);
        tagq.push_back(tag);
    endtask

    // Every entry corresponds to exactly one sampling edge, so pop one per cycle.
    initial begin
        expect_t e;
        string   t;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                t = tagq.pop_front();
                checkOutput({t, ".valid"}, {31'd0, bus.out_valid}, {31'd0, e.valid});
                checkOutput({t, ".out"},   {15'd0, bus.out},       {15'd0, e.out});
                checkOutput({t, ".zero"},  {31'd0, bus.zero},      {31'd0, e.zero});
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.op       = 3'd0;
        bus.in1      = '0;
        bus.in2      = '0;
        #12;
        checkOutput("reset.out",   {15'd0, bus.out},       32'd0);
        checkOutput("reset.valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("reset.zero",  {31'd0, bus.zero},      32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("and",       1'b1, 3'd0, 16'd9,     16'd11);
        applyStimulus("add_carry", 1'b1, 3'd1, 16'd32891, 16'd33256);
        applyStimulus("sub_borrow",1'b1, 3'd2, 16'd2891,  16'd3256);
        applyStimulus("shl3",      1'b1, 3'd4, 16'd256,   16'd3);
        applyStimulus("shl_out",   1'b1, 3'd4, 16'h8001,  16'd1);
        applyStimulus("shl_big",   1'b1, 3'd4, 16'h8001,  16'd16);
        applyStimulus("asr15",     1'b1, 3'd6, 16'h8000,  16'd15);
        applyStimulus("shr15",     1'b1, 3'd5, 16'h8000,  16'd15);
        applyStimulus("sub_zero",  1'b1, 3'd2, 16'd5,     16'd5);
        applyStimulus("or",        1'b1, 3'd3, 16'h0F0F,  16'h3300);
        applyStimulus("idle_hold", 1'b0, 3'd1, 16'hFFFF,  16'hFFFF);
        applyStimulus("xor",       1'b1, 3'd7, 16'hA5A5,  16'h0FF0);
        applyStimulus("shr0",      1'b1, 3'd5, 16'h8123,  16'd0);
        applyStimulus("asr0",      1'b1, 3'd6, 16'h8123,  16'd0);
        applyStimulus("asr_big",   1'b1, 3'd6, 16'h8123,  16'h0100);
        applyStimulus("asr_pos",   1'b1, 3'd6, 16'h4000,  16'd14);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] b;
            b = (i % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 17));
            applyStimulus($sformatf("rand%0d", i), ($urandom_range(0, 4) != 0),
                          3'($urandom_range(0, 7)), 16'($urandom), b);
        end

        // Leave a nonzero valid result on out, then reset between clock edges.
        applyStimulus("pre_reset", 1'b1, 3'd3, 16'h1234, 16'h0001);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset.out",   {15'd0, bus.out},       32'd0);
        checkOutput("async_reset.valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("async_reset.zero",  {31'd0, bus.zero},      32'd1);
        held_out  = '0;
        held_zero = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus("post_reset", 1'b1, 3'd1, 16'hFFFF, 16'd1);
        applyStimulus("post_idle",  1'b0, 3'd0, 16'd0,    16'd0);

        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("drain", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
